regfile_mp: RTL and testbench
=============================

Name: regfile_mp

Overview:
Parametrised multi-read-port integer register file with two additions: an optional write-to-read bypass and a per-register busy scoreboard. The decode stage reads operands and issues destination reservations. Writeback writes results and releases those reservations. The pipeline uses the busy outputs for RAW hazard stalls.

Parameters:
DATA_WIDTH, 32, register width in bits
REG_NUM, 32, number of architectural registers (power of 2)
RADDR_WIDTH, 5, address width; must equal log2(REG_NUM)
RD_PORTS, 2, number of read ports (1..4)
BYPASS, 1, 1 = same-cycle write data forwarded to matching reads; 0 = reads return stored value
ZERO_REG, 1, 1 = register 0 hardwired to zero and never busy

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active high
rd_en  input  RD_PORTS  per-port read enable
rd_addr  input  RD_PORTS*RADDR_WIDTH  read addresses, port p at bits [p*RADDR_WIDTH +: RADDR_WIDTH]
rd_data  output  RD_PORTS*DATA_WIDTH  read data, port p at [p*DATA_WIDTH +: DATA_WIDTH]
rd_busy  output  RD_PORTS  per-port: addressed register has an outstanding reservation
wen  input  1  write enable
waddr  input  RADDR_WIDTH  write address
wdata  input  DATA_WIDTH  write data
issue_en  input  1  reserve destination register (set busy)
issue_addr  input  RADDR_WIDTH  register to reserve
flush  input  1  clear all busy bits (pipeline flush); data untouched

Behaviour:
- Reset: on a rising clk edge with rst=1, all REG_NUM registers go to 0 and all busy bits go to 0; rst overrides wen, issue_en and flush.
- Write: if wen=1 and not (ZERO_REG=1 and waddr=0), reg[waddr] <= wdata at the edge.
- Read path is combinational, with zero-cycle latency, per port p:
  - rd_en[p]=0: rd_data=0 and rd_busy=0.
  - BYPASS=1, wen=1, waddr=rd_addr[p], and the address is writable: rd_data=wdata and rd_busy=0 (the result is arriving now).
  - Otherwise: rd_data=reg[rd_addr[p]] and rd_busy=busy[rd_addr[p]].
  - With BYPASS=0, a read of the register being written returns the old value and the current busy bit.
  - ZERO_REG=1 and address 0: rd_data=0 and rd_busy=0 always.
- All read ports are independent; identical addresses on several ports return identical results.
- Scoreboard update at each edge, in priority order:
  1. rst → all busy=0.
  2. flush → all busy=0, ignoring issue_en and wen this cycle. The wen data write still occurs.
  3. Otherwise:
     - wen clears busy[waddr].
     - issue_en sets busy[issue_addr].
     - If both hit the same address, set wins: the new producer's reservation is kept.
- issue_addr=0 with ZERO_REG=1 is ignored (register 0 is never busy).
- Issuing to an already-busy register keeps it busy; no counting, single outstanding producer per register.
- A write to a non-busy register is legal: data is updated and busy stays 0.
- During rst=1, the read outputs still reflect pre-reset contents combinationally until the edge.
- No X on outputs after reset; rd_addr values are always in range by construction (REG_NUM = 2^RADDR_WIDTH).

Test Plan:
1. Reset, then read all 32 regs on every port → rd_data=0 and rd_busy=0 everywhere; write 0xDEADBEEF to reg 0 → reg 0 still reads 0.
2. Write 0x12345678 to x5, then on the next cycle read x5 on ports 0 and 1 → both return 0x12345678. Also test with rd_en[1]=0 → port 1 returns 0.
3. BYPASS=1: wen=1, waddr=7, wdata=0xA5A5A5A5, rd_addr[0]=7 in the same cycle → rd_data[0]=0xA5A5A5A5 immediately. BYPASS=0 build, same stimulus → old value returned, new value on the following cycle.
4. Scoreboard: issue x9, next cycle read x9 → rd_busy=1. Write x9 and read in the same cycle → BYPASS=1 gives busy=0; BYPASS=0 gives busy=1 that cycle and 0 the next.
5. Simultaneous wen and issue_en on x3 while x3 is busy → x3 data updated and busy stays 1. Simultaneous wen on x4 and issue_en on x6 → x4 becomes not busy and x6 becomes busy.
6. Issue x1, x2 and x31, then flush together with issue_en on x10 → all busy=0 next cycle, x10 not busy. Assert rst mid-sequence with wen=1 → all data=0 and busy=0, and the write is discarded.

Source files
------------

// File: rtl/regfile_mp.sv
// regfile_mp: multi-read-port register file with optional write-to-read
// bypass and a per-register busy scoreboard for RAW hazard detection.
module regfile_mp #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned REG_NUM     = 32,
  parameter int unsigned RADDR_WIDTH = 5,
  parameter int unsigned RD_PORTS    = 2,
  parameter int unsigned BYPASS      = 1,
  parameter int unsigned ZERO_REG    = 1
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [RD_PORTS-1:0]              rd_en,
  input  logic [RD_PORTS*RADDR_WIDTH-1:0]  rd_addr,
  output logic [RD_PORTS*DATA_WIDTH-1:0]   rd_data,
  output logic [RD_PORTS-1:0]              rd_busy,
  input  logic                             wen,
  input  logic [RADDR_WIDTH-1:0]           waddr,
  input  logic [DATA_WIDTH-1:0]            wdata,
  input  logic                             issue_en,
  input  logic [RADDR_WIDTH-1:0]           issue_addr,
  input  logic                             flush
);

  logic [REG_NUM-1:0][DATA_WIDTH-1:0] regs_q, regs_d;
  logic [REG_NUM-1:0]                 busy_q, busy_d;
  logic                               wr_ok;
  logic                               iss_ok;
  logic [RADDR_WIDTH-1:0]             ra;

  // Register 0 is neither writable nor reservable when hardwired to zero.
  always_comb begin
    wr_ok  = wen      && !((ZERO_REG != 0) && (waddr == '0));
    iss_ok = issue_en && !((ZERO_REG != 0) && (issue_addr == '0));
  end

  // Next data state: single write port; flush does not block the data write.
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) begin
      regs_d[waddr] = wdata;
    end
  end

  // Next scoreboard state: flush clears everything, otherwise release then reserve (set wins).
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wen) begin
        busy_d[waddr] = 1'b0;
      end
      if (iss_ok) begin
        busy_d[issue_addr] = 1'b1;
      end
    end
    if (ZERO_REG != 0) begin
      busy_d[0] = 1'b0;
    end
  end

  // State registers with synchronous reset overriding all updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '0;
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      busy_q <= busy_d;
    end
  end

  // Combinational read ports, each independent, with optional same-cycle forwarding.
  always_comb begin
    rd_data = '0;
    rd_busy = '0;
    ra      = '0;
    for (int unsigned p = 0; p < RD_PORTS; p++) begin
      ra = rd_addr[p*RADDR_WIDTH +: RADDR_WIDTH];
      if (rd_en[p] && !((ZERO_REG != 0) && (ra == '0))) begin
        if ((BYPASS != 0) && wr_ok && (waddr == ra)) begin
          rd_data[p*DATA_WIDTH +: DATA_WIDTH] = wdata;
          rd_busy[p]                          = 1'b0;
        end else begin
          rd_data[p*DATA_WIDTH +: DATA_WIDTH] = regs_q[ra];
          rd_busy[p]                          = busy_q[ra];
        end
      end
    end
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Testbench for regfile_mp: a bypassing and a non-bypassing instance share
// stimulus; directed scenarios plus randomized traffic against a model.
module tb_regfile_mp;

  localparam int DW = 32;
  localparam int RN = 32;
  localparam int AW = 5;
  localparam int RP = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [RP-1:0]  rd_en;
  logic [RP*AW-1:0] rd_addr;
  logic           wen;
  logic [AW-1:0]  waddr;
  logic [DW-1:0]  wdata;
  logic           issue_en;
  logic [AW-1:0]  issue_addr;
  logic           flush;

  logic [RP*DW-1:0] rd_data_b, rd_data_n;
  logic [RP-1:0]    rd_busy_b, rd_busy_n;

  int vectors    = 0;
  int miscompares = 0;

  logic [DW-1:0] m_reg  [RN];
  bit            m_busy [RN];

  always #5 clk = ~clk;

  regfile_mp #(.DATA_WIDTH(DW), .REG_NUM(RN), .RADDR_WIDTH(AW), .RD_PORTS(RP),
               .BYPASS(1), .ZERO_REG(1)) dut (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_b), .rd_busy(rd_busy_b),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush));

  regfile_mp #(.DATA_WIDTH(DW), .REG_NUM(RN), .RADDR_WIDTH(AW), .RD_PORTS(RP),
               .BYPASS(0), .ZERO_REG(1)) dut_nb (
    .clk(clk), .rst(rst), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data_n), .rd_busy(rd_busy_n),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .issue_en(issue_en), .issue_addr(issue_addr), .flush(flush));

  // Expected read data from the architectural model.
  function automatic logic [RP*DW-1:0] exp_data(input bit byp);
    logic [RP*DW-1:0] r;
    logic [AW-1:0]    a;
    r = '0;
    for (int p = 0; p < RP; p++) begin
      a = rd_addr[p*AW +: AW];
      if (rd_en[p] && a != 0) begin
        if (byp && wen && waddr == a) r[p*DW +: DW] = wdata;
        else                          r[p*DW +: DW] = m_reg[a];
      end
    end
    return r;
  endfunction

  // Expected busy flags from the architectural model.
  function automatic logic [RP-1:0] exp_busy(input bit byp);
    logic [RP-1:0] r;
    logic [AW-1:0] a;
    r = '0;
    for (int p = 0; p < RP; p++) begin
      a = rd_addr[p*AW +: AW];
      if (rd_en[p] && a != 0) begin
        if (byp && wen && waddr == a) r[p] = 1'b0;
        else                          r[p] = m_busy[a];
      end
    end
    return r;
  endfunction

  // Advance one clock, applying the architectural update rules to the model.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < RN; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      if (wen && waddr != 0) m_reg[waddr] = wdata;
      if (flush) begin
        for (int i = 0; i < RN; i++) m_busy[i] = 1'b0;
      end else begin
        if (wen) m_busy[waddr] = 1'b0;
        if (issue_en && issue_addr != 0) m_busy[issue_addr] = 1'b1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle();
    rst = 1'b0; wen = 1'b0; issue_en = 1'b0; flush = 1'b0;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1, input logic [1:0] en);
    rd_addr = {a1, a0};
    rd_en   = en;
  endtask

  task automatic test_reset();
    idle();
    for (int a = 0; a < RN; a++) begin
      set_rd(AW'(a), AW'(RN - 1 - a), 2'b11);
      #1;
      vectors++;
      if (rd_data_b !== '0 || rd_busy_b !== '0 || rd_data_n !== '0 || rd_busy_n !== '0) begin
        $display("FAIL reset_read a=%0d: got %h/%b %h/%b expected 0/0", a,
                 rd_data_b, rd_busy_b, rd_data_n, rd_busy_n);
        miscompares++;
      end
      tick();
    end
    wen = 1'b1; waddr = 0; wdata = 32'hDEADBEEF; set_rd(0, 0, 2'b11);
    #1;
    vectors++;
    if (rd_data_b !== '0 || rd_busy_b !== '0) begin
      $display("FAIL x0_bypass: got %h/%b expected 0/0", rd_data_b, rd_busy_b);
      miscompares++;
    end
    tick();
    idle();
    #1;
    vectors++;
    if (rd_data_b !== '0 || rd_data_n !== '0) begin
      $display("FAIL x0_write: got %h %h expected 0", rd_data_b, rd_data_n);
      miscompares++;
    end
  endtask

  task automatic test_write_read();
    idle();
    wen = 1'b1; waddr = 5; wdata = 32'h12345678; set_rd(1, 1, 2'b00);
    tick();
    idle();
    set_rd(5, 5, 2'b11);
    #1;
    vectors++;
    if (rd_data_b !== {2{32'h12345678}} || rd_data_n !== {2{32'h12345678}}) begin
      $display("FAIL wr_rd_both: got %h %h expected %h", rd_data_b, rd_data_n, {2{32'h12345678}});
      miscompares++;
    end
    set_rd(5, 5, 2'b01);
    #1;
    vectors++;
    if (rd_data_b !== {32'h0, 32'h12345678} || rd_data_n !== {32'h0, 32'h12345678}) begin
      $display("FAIL wr_rd_en1off: got %h %h expected %h", rd_data_b, rd_data_n, {32'h0, 32'h12345678});
      miscompares++;
    end
    tick();
  endtask

  task automatic test_bypass();
    idle();
    wen = 1'b1; waddr = 7; wdata = 32'h11111111;
    tick();
    wdata = 32'hA5A5A5A5; set_rd(7, 0, 2'b01);
    #1;
    vectors++;
    if (rd_data_b[31:0] !== 32'hA5A5A5A5) begin
      $display("FAIL bypass_on: got %h expected a5a5a5a5", rd_data_b[31:0]);
      miscompares++;
    end
    vectors++;
    if (rd_data_n[31:0] !== 32'h11111111) begin
      $display("FAIL bypass_off_old: got %h expected 11111111", rd_data_n[31:0]);
      miscompares++;
    end
    tick();
    idle();
    #1;
    vectors++;
    if (rd_data_b[31:0] !== 32'hA5A5A5A5 || rd_data_n[31:0] !== 32'hA5A5A5A5) begin
      $display("FAIL bypass_next: got %h %h expected a5a5a5a5", rd_data_b[31:0], rd_data_n[31:0]);
      miscompares++;
    end
  endtask

  task automatic test_scoreboard();
    idle();
    issue_en = 1'b1; issue_addr = 9;
    tick();
    idle();
    set_rd(9, 9, 2'b11);
    #1;
    vectors++;
    if (rd_busy_b !== 2'b11 || rd_busy_n !== 2'b11) begin
      $display("FAIL sb_issue: got %b %b expected 11", rd_busy_b, rd_busy_n);
      miscompares++;
    end
    wen = 1'b1; waddr = 9; wdata = 32'h00000099;
    #1;
    vectors++;
    if (rd_busy_b !== 2'b00 || rd_data_b[31:0] !== 32'h99) begin
      $display("FAIL sb_wr_bypass: got %b/%h expected 00/00000099", rd_busy_b, rd_data_b[31:0]);
      miscompares++;
    end
    vectors++;
    if (rd_busy_n !== 2'b11) begin
      $display("FAIL sb_wr_nobypass: got %b expected 11", rd_busy_n);
      miscompares++;
    end
    tick();
    idle();
    #1;
    vectors++;
    if (rd_busy_b !== 2'b00 || rd_busy_n !== 2'b00) begin
      $display("FAIL sb_release: got %b %b expected 00", rd_busy_b, rd_busy_n);
      miscompares++;
    end
  endtask

  task automatic test_simultaneous();
    idle();
    issue_en = 1'b1; issue_addr = 3;
    tick();
    wen = 1'b1; waddr = 3; wdata = 32'h33333333;
    tick();
    idle();
    set_rd(3, 3, 2'b11);
    #1;
    vectors++;
    if (rd_data_n !== {2{32'h33333333}} || rd_busy_b !== 2'b11 || rd_busy_n !== 2'b11) begin
      $display("FAIL same_addr: got %h/%b/%b expected 3333../11/11", rd_data_n, rd_busy_b, rd_busy_n);
      miscompares++;
    end
    issue_en = 1'b1; issue_addr = 4;
    tick();
    issue_addr = 6; wen = 1'b1; waddr = 4; wdata = 32'h44444444;
    tick();
    idle();
    set_rd(4, 6, 2'b11);
    #1;
    vectors++;
    if (rd_busy_b !== 2'b10 || rd_busy_n !== 2'b10) begin
      $display("FAIL diff_addr: got %b %b expected 10", rd_busy_b, rd_busy_n);
      miscompares++;
    end
  endtask

  task automatic test_flush_reset();
    idle();
    issue_en = 1'b1;
    issue_addr = 1;  tick();
    issue_addr = 2;  tick();
    issue_addr = 31; tick();
    idle();
    set_rd(1, 31, 2'b11);
    #1;
    vectors++;
    if (rd_busy_b !== 2'b11) begin
      $display("FAIL pre_flush: got %b expected 11", rd_busy_b);
      miscompares++;
    end
    flush = 1'b1; issue_en = 1'b1; issue_addr = 10;
    tick();
    idle();
    #1;
    vectors++;
    if (rd_busy_b !== 2'b00 || rd_busy_n !== 2'b00) begin
      $display("FAIL flush_1_31: got %b %b expected 00", rd_busy_b, rd_busy_n);
      miscompares++;
    end
    set_rd(2, 10, 2'b11);
    #1;
    vectors++;
    if (rd_busy_b !== 2'b00 || rd_busy_n !== 2'b00) begin
      $display("FAIL flush_2_10: got %b %b expected 00", rd_busy_b, rd_busy_n);
      miscompares++;
    end
    issue_en = 1'b1; issue_addr = 12;
    tick();
    idle();
    rst = 1'b1; wen = 1'b1; waddr = 20; wdata = 32'h0000CAFE; set_rd(5, 12, 2'b11);
    #1;
    vectors++;
    if (rd_data_n[31:0] !== 32'h12345678 || rd_busy_n[1] !== 1'b1) begin
      $display("FAIL pre_reset_view: got %h/%b expected 12345678/1", rd_data_n[31:0], rd_busy_n[1]);
      miscompares++;
    end
    tick();
    idle();
    set_rd(20, 12, 2'b11);
    #1;
    vectors++;
    if (rd_data_b !== '0 || rd_busy_b !== 2'b00 || rd_data_n !== '0 || rd_busy_n !== 2'b00) begin
      $display("FAIL mid_reset: got %h/%b %h/%b expected 0/00", rd_data_b, rd_busy_b, rd_data_n, rd_busy_n);
      miscompares++;
    end
    set_rd(5, 7, 2'b11);
    #1;
    vectors++;
    if (rd_data_b !== '0) begin
      $display("FAIL reset_data: got %h expected 0", rd_data_b);
      miscompares++;
    end
  endtask

  task automatic test_random();
    logic [RP*DW-1:0] ed;
    logic [RP-1:0]    eb;
    for (int n = 0; n < 400; n++) begin
      rst        = ($urandom_range(0, 63) == 0);
      flush      = ($urandom_range(0, 15) == 0);
      wen        = $urandom_range(0, 1);
      waddr      = AW'($urandom_range(0, 7));
      wdata      = $urandom;
      issue_en   = $urandom_range(0, 1);
      issue_addr = AW'($urandom_range(0, 7));
      rd_en      = RP'($urandom_range(0, 3));
      rd_addr    = {AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7))};
      if ($urandom_range(0, 2) == 0) rd_addr[AW-1:0] = waddr;
      if (n % 50 == 0) begin
        waddr = AW'($urandom); issue_addr = AW'($urandom); rd_addr = RP*AW'($urandom);
      end
      #1;
      ed = exp_data(1'b1);
      eb = exp_busy(1'b1);
      vectors++;
      if (rd_data_b !== ed || rd_busy_b !== eb) begin
        $display("FAIL rand_byp n=%0d: got %h/%b expected %h/%b", n, rd_data_b, rd_busy_b, ed, eb);
        miscompares++;
      end
      ed = exp_data(1'b0);
      eb = exp_busy(1'b0);
      vectors++;
      if (rd_data_n !== ed || rd_busy_n !== eb) begin
        $display("FAIL rand_nobyp n=%0d: got %h/%b expected %h/%b", n, rd_data_n, rd_busy_n, ed, eb);
        miscompares++;
      end
      tick();
    end
    idle();
  endtask

  initial begin
    rst = 1'b1; wen = 1'b0; waddr = '0; wdata = '0;
    issue_en = 1'b0; issue_addr = '0; flush = 1'b0;
    rd_en = '0; rd_addr = '0;
    @(negedge clk);
    tick();
    tick();
    test_reset();
    test_write_read();
    test_bypass();
    test_scoreboard();
    test_simultaneous();
    test_flush_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
